// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - VGA test-pattern generator: four patterns, debounced swap, applied at frame start.
// Optional: define VGA_PATTERN_AUTOCYCLE_EN to also advance the pattern every 256 frames.
module vga_pattern_gen #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        swap,
  input  logic [9:0]  hCounter,
  input  logic [9:0]  vCounter,
  output logic [23:0] color,
  output logic [1:0]  pattern
);

  typedef enum logic [1:0] {
    BARS     = 2'd0,
    CHECKER  = 2'd1,
    GRADIENT = 2'd2,
    SOLID    = 2'd3
  } pattern_t;

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1, r_sync2, r_stable, r_pending;
  logic [CW-1:0] r_db_cnt;
  pattern_t      r_pattern, w_pattern_next;
  logic [23:0]   r_color, w_color_next, w_bar_color;
  logic [2:0]    w_bar;
  logic          w_accept, w_rise, w_frame_start, w_advance, w_active, w_auto;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= swap;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_stable) begin
        r_db_cnt <= '0;
      end else if (w_accept) begin
        r_stable <= r_sync2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  // w_rise marks the cycle in which stable goes high, so a press landing on frame start counts
  assign w_accept      = (r_sync2 != r_stable) && (r_db_cnt == DB_LAST);
  assign w_rise        = w_accept && r_sync2;
  assign w_frame_start = (hCounter == 10'd0) && (vCounter == 10'd0);

`ifdef VGA_PATTERN_AUTOCYCLE_EN
  logic [7:0] r_frame_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_cnt <= 8'd0;
    end else if (w_frame_start) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign w_auto = w_frame_start && (r_frame_cnt == 8'hFF);
`else
  assign w_auto = 1'b0;
`endif

  assign w_advance = w_frame_start && (r_pending || w_rise || w_auto);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= 1'b0;
    end else if (w_advance) begin
      r_pending <= 1'b0;
    end else if (w_rise) begin
      r_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pattern <= BARS;
      r_color   <= 24'h000000;
    end else begin
      r_pattern <= w_pattern_next;
      r_color   <= w_color_next;
    end
  end

  always_comb begin
    w_pattern_next = r_pattern;
    if (w_advance) begin
      case (r_pattern)
        BARS:     w_pattern_next = CHECKER;
        CHECKER:  w_pattern_next = GRADIENT;
        GRADIENT: w_pattern_next = SOLID;
        default:  w_pattern_next = BARS;
      endcase
    end
  end

  always_comb begin
    w_bar = 3'd7;
    if      (hCounter < 10'd80)  w_bar = 3'd0;
    else if (hCounter < 10'd160) w_bar = 3'd1;
    else if (hCounter < 10'd240) w_bar = 3'd2;
    else if (hCounter < 10'd320) w_bar = 3'd3;
    else if (hCounter < 10'd400) w_bar = 3'd4;
    else if (hCounter < 10'd480) w_bar = 3'd5;
    else if (hCounter < 10'd560) w_bar = 3'd6;
  end

  always_comb begin
    w_bar_color = 24'h000000;
    case (w_bar)
      3'd0:    w_bar_color = 24'hFFFFFF;
      3'd1:    w_bar_color = 24'hFFFF00;
      3'd2:    w_bar_color = 24'h00FFFF;
      3'd3:    w_bar_color = 24'h00FF00;
      3'd4:    w_bar_color = 24'hFF00FF;
      3'd5:    w_bar_color = 24'hFF0000;
      3'd6:    w_bar_color = 24'h0000FF;
      default: w_bar_color = 24'h000000;
    endcase
  end

  assign w_active = (hCounter < 10'(H_ACTIVE)) && (vCounter < 10'(V_ACTIVE));

  // Rendered from the next pattern so the first pixel of a new frame already shows it
  always_comb begin
    w_color_next = 24'h000000;
    if (w_active) begin
      case (w_pattern_next)
        BARS:     w_color_next = w_bar_color;
        CHECKER:  w_color_next = (hCounter[5] ^ vCounter[5]) ? 24'hFFFFFF : 24'h000000;
        GRADIENT: w_color_next = {hCounter[9:2], vCounter[8:1], 8'h00};
        default:  w_color_next = 24'h0000FF;
      endcase
    end
  end

  assign color   = r_color;
  assign pattern = r_pattern;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - scoreboard bench for vga_pattern_gen with a frame-level reference model.
module tb_vga_pattern_gen;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        swap;
  logic [9:0]  hCounter, vCounter;
  logic [23:0] color;
  logic [1:0]  pattern;

  vga_pattern_gen #(.DEBOUNCE_CYCLES(D), .H_ACTIVE(640), .V_ACTIVE(480)) dut (
    .clk(clk), .reset(reset), .swap(swap),
    .hCounter(hCounter), .vCounter(vCounter),
    .color(color), .pattern(pattern)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] col;
    logic [1:0]  pat;
    int          h;
    int          v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_pattern = 0;
  bit   m_pending = 0;
  int   m_frames  = 0;

  function automatic logic [23:0] ref_color(input int h, input int v, input int p);
    int bar;
    if (h >= 640 || v >= 480) return 24'h000000;
    case (p)
      0: begin
        bar = h / 80;
        case (bar)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      1: return (((h / 32) % 2) != ((v / 32) % 2)) ? 24'hFFFFFF : 24'h000000;
      2: return {8'((h / 4) % 256), 8'((v / 2) % 256), 8'h00};
      default: return 24'h0000FF;
    endcase
  endfunction

  // One pixel clock: drive a position, update the model, queue the expected output
  task automatic step(input int h, input int v);
    exp_t e;
    bit adv;
    @(negedge clk);
    hCounter = 10'(h);
    vCounter = 10'(v);
    if (h == 0 && v == 0) begin
      adv = m_pending;
`ifdef VGA_PATTERN_AUTOCYCLE_EN
      m_frames = (m_frames + 1) % 256;
      if (m_frames == 0) adv = 1'b1;
`endif
      if (adv) m_pattern = (m_pattern + 1) % 4;
      m_pending = 1'b0;
    end
    e.col = ref_color(h, v, m_pattern);
    e.pat = 2'(m_pattern);
    e.h = h;
    e.v = v;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    int h, v;
    for (int i = 0; i < n; i++) begin
      h = $urandom_range(0, 799);
      v = $urandom_range(0, 524);
      if (h == 0 && v == 0) h = 1;
      step(h, v);
    end
  endtask

  task automatic frame_start();
    step(0, 0);
  endtask

  task automatic press();
    swap = 1'b1;
    idle(D + 6);
    m_pending = 1'b1;
    swap = 1'b0;
    idle(D + 6);
  endtask

  task automatic glitch();
    swap = 1'b1;
    idle(2);
    swap = 1'b0;
    idle(D + 6);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    swap = 1'b0;
    hCounter = 10'd5;
    vCounter = 10'd5;
    @(posedge clk);
    #1;
    checks++;
    if (color !== 24'h000000 || pattern !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: color=%h pattern=%0d, required color=000000 pattern=0", color, pattern);
    end
    @(negedge clk);
    reset = 1'b0;
    m_pattern = 0;
    m_pending = 1'b0;
    m_frames = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (color !== e.col || pattern !== e.pat) begin
          errors++;
          $display("FAIL pixel h=%0d v=%0d: color=%h pattern=%0d, required color=%h pattern=%0d",
                   e.h, e.v, color, pattern, e.col, e.pat);
        end
      end
    end
  end

  initial begin : stimulus
    int r;
    reset = 1'b1;
    swap = 1'b0;
    hCounter = 10'd5;
    vCounter = 10'd5;
    repeat (3) @(negedge clk);
    do_reset();

    // Bars at pattern 0, including the last bar and the blanking edge
    step(100, 10);
    step(639, 10);
    step(640, 10);
    step(0, 480);
    step(79, 479);
    step(80, 479);
    idle(20);

    // Long press mid-frame takes effect only at frame start
    press();
    frame_start();
    step(32, 0);
    step(32, 32);
    step(31, 31);
    idle(10);

    // Short glitch produces no advance
    glitch();
    frame_start();
    idle(5);

    // Gradient
    press();
    frame_start();
    step(400, 200);
    step(639, 479);
    step(3, 1);
    idle(10);

    // Three presses in one frame at pattern 3 give a single wrap to 0
    press();
    frame_start();
    idle(5);
    press();
    press();
    press();
    frame_start();
    idle(5);
    frame_start();
    idle(5);

    // Held button advances once only
    swap = 1'b1;
    idle(D + 6);
    m_pending = 1'b1;
    frame_start();
    idle(5);
    frame_start();
    idle(5);
    swap = 1'b0;
    idle(D + 6);
    frame_start();
    idle(5);

    // Reset discards a pending request
    press();
    press();
    do_reset();
    idle(3);
    frame_start();
    idle(5);

    // Randomized mix of operations
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5)       idle($urandom_range(1, 8));
      else if (r < 7)  press();
      else if (r == 7) glitch();
      else             frame_start();
    end

    // Frame counting from reset: with autocycle the 256th frame start advances
    do_reset();
    for (int i = 0; i < 260; i++) begin
      frame_start();
      idle(2);
    end

    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
